id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: W, 32, datapath width of PC and register-value fields.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 flush  in  1  branch taken in EX; next captured entry becomes a bubble.
REQ-006 freeze  in  1  hazard stall; hold current contents.
REQ-007 valid_in  in  1  ID holds a real instruction.
REQ-008 PC_in  in  W  PC+4 of the ID instruction.
REQ-009 WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in  in  1 each  ID control bits.
REQ-010 EXE_CMD_in  in  4  ALU command.
REQ-011 Val_Rn_in, Val_Rm_in  in  W each  register-file read values.
REQ-012 imm_in  in  1  immediate-operand flag.
REQ-013 shift_operand_in  in  12  shifter operand field.
REQ-014 signed_immed_24_in  in  24  branch offset field.
REQ-015 Dest_in, src1_in, src2_in  in  4 each  destination and source register numbers.
REQ-016 status_in  in  4  current NZCV from the status register.
REQ-017 Outputs: one registered output per input in REQ-007..REQ-016, same width, suffix _out.

Function
REQ-018 All outputs driven directly from flops; no combinational path from input to output.
REQ-019 Per rising edge, priority: rst > flush > freeze > load.
REQ-020 Load (no rst/flush/freeze): every _out takes its _in value one cycle later.
REQ-021 Freeze (no rst/flush): every _out holds its previous value, including valid_out.
REQ-022 Flush: valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out cleared to 0.
REQ-023 Flush: all other outputs cleared to 0; EXE_CMD_out = 4'b0000.
REQ-024 Flush and freeze in the same cycle: flush wins; a bubble is captured.
REQ-025 valid_in = 0 on a load: control bits in REQ-022 loaded as 0 regardless of their inputs; data fields loaded as presented.
REQ-026 A captured bubble has no architectural effect: no writeback, no memory access, no branch, no status update.
REQ-027 status_out is sampled with the instruction and stays bound to it while frozen.
REQ-028 Latency exactly 1 cycle; throughput 1 entry/cycle when not frozen.
REQ-029 Freeze for N cycles followed by release: the entry loaded on the first unfrozen edge is the input present at that edge; no held data is lost or duplicated.

Reset
REQ-030 On rst at a clock edge, every output goes to 0, including valid_out and EXE_CMD_out.
REQ-031 rst asserted mid-freeze or mid-flush overrides both; the first edge after rst deasserts behaves as a normal load.
REQ-032 No output changes between clock edges, including while rst is asserted.

Verification
REQ-033 Load: PC_in=0x00000008, Val_Rn_in=0x12345678, WB_EN_in=1, Dest_in=3, valid_in=1 -> next cycle same values on _out, valid_out=1.
REQ-034 Freeze: load entry A (PC_in=0x10), hold freeze=1 for 3 cycles while PC_in=0x14 -> PC_out=0x10 for all 3 cycles; release -> PC_out=0x14.
REQ-035 Flush: MEM_W_EN_in=1, B_in=1, S_in=1, flush=1 -> next cycle all control bits 0, valid_out=0, PC_out=0.
REQ-036 Simultaneous: flush=1, freeze=1, valid entry held -> next cycle bubble (valid_out=0, WB_EN_out=0).
REQ-037 Reset: rst=1 while freeze=1 and a valid entry is held -> next cycle all outputs 0; rst=0 with PC_in=0x20, valid_in=1 -> PC_out=0x20 one cycle later.
REQ-038 Invalid input: valid_in=0, WB_EN_in=1, MEM_R_EN_in=1, Val_Rm_in=0xFFFF0000 -> WB_EN_out=0, MEM_R_EN_out=0, Val_Rm_out=0xFFFF0000.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: the decode-side fields presented by ID
// (_in) and the registered copies consumed by EX (_out).
interface id_ex_reg_if #(
    parameter int W = 32
);
    logic         valid_in;
    logic [W-1:0] PC_in;
    logic         WB_EN_in;
    logic         MEM_R_EN_in;
    logic         MEM_W_EN_in;
    logic         B_in;
    logic         S_in;
    logic [3:0]   EXE_CMD_in;
    logic [W-1:0] Val_Rn_in;
    logic [W-1:0] Val_Rm_in;
    logic         imm_in;
    logic [11:0]  shift_operand_in;
    logic [23:0]  signed_immed_24_in;
    logic [3:0]   Dest_in;
    logic [3:0]   src1_in;
    logic [3:0]   src2_in;
    logic [3:0]   status_in;

    logic         valid_out;
    logic [W-1:0] PC_out;
    logic         WB_EN_out;
    logic         MEM_R_EN_out;
    logic         MEM_W_EN_out;
    logic         B_out;
    logic         S_out;
    logic [3:0]   EXE_CMD_out;
    logic [W-1:0] Val_Rn_out;
    logic [W-1:0] Val_Rm_out;
    logic         imm_out;
    logic [11:0]  shift_operand_out;
    logic [23:0]  signed_immed_24_out;
    logic [3:0]   Dest_out;
    logic [3:0]   src1_out;
    logic [3:0]   src2_out;
    logic [3:0]   status_out;

    // ID stage side: drives the decoded fields, may observe the EX copy.
    modport master (
        output valid_in, PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
               EXE_CMD_in, Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in,
               signed_immed_24_in, Dest_in, src1_in, src2_in, status_in,
        input  valid_out, PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out,
               S_out, EXE_CMD_out, Val_Rn_out, Val_Rm_out, imm_out,
               shift_operand_out, signed_immed_24_out, Dest_out, src1_out,
               src2_out, status_out
    );

    // Pipeline register side: captures the decoded fields, drives EX.
    modport slave (
        input  valid_in, PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
               EXE_CMD_in, Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in,
               signed_immed_24_in, Dest_in, src1_in, src2_in, status_in,
        output valid_out, PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out,
               S_out, EXE_CMD_out, Val_Rn_out, Val_Rm_out, imm_out,
               shift_operand_out, signed_immed_24_out, Dest_out, src1_out,
               src2_out, status_out
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Every output is a flop. Edge priority is
// reset, then flush (capture a bubble), then freeze (hold), then load.
// A non-valid instruction is loaded with its side-effect bits forced low
// so that it can never write back, touch memory, branch or set flags.
module id_ex_reg #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       freeze,
    id_ex_reg_if.slave bus
);

    // Single register stage for the whole ID/EX entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bus.valid_out           <= 1'b0;
            bus.PC_out              <= '0;
            bus.WB_EN_out           <= 1'b0;
            bus.MEM_R_EN_out        <= 1'b0;
            bus.MEM_W_EN_out        <= 1'b0;
            bus.B_out               <= 1'b0;
            bus.S_out               <= 1'b0;
            bus.EXE_CMD_out         <= 4'b0000;
            bus.Val_Rn_out          <= '0;
            bus.Val_Rm_out          <= '0;
            bus.imm_out             <= 1'b0;
            bus.shift_operand_out   <= '0;
            bus.signed_immed_24_out <= '0;
            bus.Dest_out            <= '0;
            bus.src1_out            <= '0;
            bus.src2_out            <= '0;
            bus.status_out          <= '0;
        end else if (!freeze) begin
            bus.valid_out           <= bus.valid_in;
            bus.PC_out              <= bus.PC_in[W-1:0];
            bus.WB_EN_out           <= bus.WB_EN_in    & bus.valid_in;
            bus.MEM_R_EN_out        <= bus.MEM_R_EN_in & bus.valid_in;
            bus.MEM_W_EN_out        <= bus.MEM_W_EN_in & bus.valid_in;
            bus.B_out               <= bus.B_in        & bus.valid_in;
            bus.S_out               <= bus.S_in        & bus.valid_in;
            bus.EXE_CMD_out         <= bus.EXE_CMD_in;
            bus.Val_Rn_out          <= bus.Val_Rn_in;
            bus.Val_Rm_out          <= bus.Val_Rm_in;
            bus.imm_out             <= bus.imm_in;
            bus.shift_operand_out   <= bus.shift_operand_in;
            bus.signed_immed_24_out <= bus.signed_immed_24_in;
            bus.Dest_out            <= bus.Dest_in;
            bus.src1_out            <= bus.src1_in;
            bus.src2_out            <= bus.src2_in;
            bus.status_out          <= bus.status_in;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a cycle-level reference model of the
// ID/EX entry plus directed checks with hand-computed values.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic [3:0]  exe;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] off;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  st;
    } ent_t;

    logic clk = 1'b0;
    logic rst, flush, freeze;
    ent_t drv;
    ent_t dut_o;
    ent_t expv;
    bit   armed = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.W(32)) bus ();

    id_ex_reg #(.W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .bus    (bus.slave)
    );

    assign bus.valid_in           = drv.valid;
    assign bus.PC_in              = drv.pc;
    assign bus.WB_EN_in           = drv.wb;
    assign bus.MEM_R_EN_in        = drv.mr;
    assign bus.MEM_W_EN_in        = drv.mw;
    assign bus.B_in               = drv.b;
    assign bus.S_in               = drv.s;
    assign bus.EXE_CMD_in         = drv.exe;
    assign bus.Val_Rn_in          = drv.rn;
    assign bus.Val_Rm_in          = drv.rm;
    assign bus.imm_in             = drv.imm;
    assign bus.shift_operand_in   = drv.sh;
    assign bus.signed_immed_24_in = drv.off;
    assign bus.Dest_in            = drv.dest;
    assign bus.src1_in            = drv.s1;
    assign bus.src2_in            = drv.s2;
    assign bus.status_in          = drv.st;

    assign dut_o = {bus.valid_out, bus.PC_out, bus.WB_EN_out, bus.MEM_R_EN_out,
                    bus.MEM_W_EN_out, bus.B_out, bus.S_out, bus.EXE_CMD_out,
                    bus.Val_Rn_out, bus.Val_Rm_out, bus.imm_out,
                    bus.shift_operand_out, bus.signed_immed_24_out, bus.Dest_out,
                    bus.src1_out, bus.src2_out, bus.status_out};

    // What EX should see for an instruction accepted from ID: a non-valid
    // slot carries its data fields but none of its side effects.
    function automatic ent_t accept(input ent_t e);
        ent_t r = e;
        if (!e.valid) begin
            r.wb = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.b = 1'b0; r.s = 1'b0;
        end
        return r;
    endfunction

    // Reference model: the entry EX should hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            expv = '0;
            armed = 1'b1;
        end else if (flush) begin
            expv = '0;
        end else if (freeze) begin
            expv = expv;
        end else begin
            expv = accept(drv);
        end
    end

    // Compare DUT against model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            nchk++;
            if (dut_o !== expv) begin
                nfail++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, dut_o, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; drv = '0;
        drv.exe = 4'hF; drv.pc = 32'hDEAD_BEEF; drv.valid = 1'b1;
        cyc();
        chk("reset_valid", 192'(bus.valid_out), 192'(0));
        chk("reset_pc", 192'(bus.PC_out), 192'(0));
        chk("reset_exe", 192'(bus.EXE_CMD_out), 192'(0));
        rst = 1'b0;

        // Plain load
        drv = '0; drv.pc = 32'h8; drv.rn = 32'h1234_5678; drv.wb = 1'b1;
        drv.dest = 4'd3; drv.valid = 1'b1;
        cyc();
        chk("load_pc", 192'(bus.PC_out), 192'(32'h8));
        chk("load_rn", 192'(bus.Val_Rn_out), 192'(32'h1234_5678));
        chk("load_wb", 192'(bus.WB_EN_out), 192'(1));
        chk("load_dest", 192'(bus.Dest_out), 192'(3));
        chk("load_valid", 192'(bus.valid_out), 192'(1));

        // Freeze holds entry A for three cycles, release loads the new input
        drv.pc = 32'h10; drv.st = 4'h5;
        cyc();
        chk("frz_a_pc", 192'(bus.PC_out), 192'(32'h10));
        freeze = 1'b1; drv.pc = 32'h14; drv.st = 4'hA;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_hold_pc", 192'(bus.PC_out), 192'(32'h10));
            chk("frz_hold_status", 192'(bus.status_out), 192'(4'h5));
        end
        freeze = 1'b0;
        cyc();
        chk("frz_release_pc", 192'(bus.PC_out), 192'(32'h14));
        chk("frz_release_status", 192'(bus.status_out), 192'(4'hA));

        // Flush captures a bubble
        drv.mw = 1'b1; drv.b = 1'b1; drv.s = 1'b1; drv.exe = 4'hA; flush = 1'b1;
        cyc();
        chk("flush_ctrl", 192'({bus.valid_out, bus.WB_EN_out, bus.MEM_R_EN_out,
                                bus.MEM_W_EN_out, bus.B_out, bus.S_out}), 192'(0));
        chk("flush_pc", 192'(bus.PC_out), 192'(0));
        chk("flush_exe", 192'(bus.EXE_CMD_out), 192'(0));

        // Flush and freeze together: flush wins
        flush = 1'b0; drv = '0; drv.valid = 1'b1; drv.wb = 1'b1; drv.pc = 32'h44;
        cyc();
        chk("sim_pre_wb", 192'(bus.WB_EN_out), 192'(1));
        flush = 1'b1; freeze = 1'b1;
        cyc();
        chk("sim_valid", 192'(bus.valid_out), 192'(0));
        chk("sim_wb", 192'(bus.WB_EN_out), 192'(0));

        // Reset mid-freeze, then normal load
        flush = 1'b0; freeze = 1'b0; drv.pc = 32'h30;
        cyc();
        freeze = 1'b1; drv.pc = 32'h34;
        cyc();
        chk("rst_pre_pc", 192'(bus.PC_out), 192'(32'h30));
        rst = 1'b1;
        cyc();
        chk("rst_all_zero", 192'(dut_o), 192'(0));
        rst = 1'b0; freeze = 1'b0; drv.pc = 32'h20; drv.valid = 1'b1;
        cyc();
        chk("rst_after_pc", 192'(bus.PC_out), 192'(32'h20));

        // Invalid slot: control masked, data passes
        drv = '0; drv.wb = 1'b1; drv.mr = 1'b1; drv.rm = 32'hFFFF_0000;
        cyc();
        chk("inv_wb", 192'(bus.WB_EN_out), 192'(0));
        chk("inv_mr", 192'(bus.MEM_R_EN_out), 192'(0));
        chk("inv_rm", 192'(bus.Val_Rm_out), 192'(32'hFFFF_0000));

        // Mixed traffic checked by the model on every cycle
        for (int i = 0; i < 300; i++) begin
            drv = ent_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            rst    = ($urandom_range(0, 31) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
